kbd_scancode_decoder: RTL and testbench

Consumes the byte FIFO output of the PS/2 keyboard receiver and turns the raw Set-2 scancode stream into key state. It pops bytes with the receiver's `ready`/`nextdata_n` handshake and interprets `E0` (extended) and `F0` (break) prefixes. It tracks the held key and Shift state, converts make codes to ASCII, and counts key presses. Its outputs drive the seven-segment display stage.

---
 rtl/kbd_scancode_decoder.sv | 240 ++++++++++++++++++++++++
 tb/tb_kbd_scancode_decoder.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_scancode_decoder.sv
// Purpose: turns the PS/2 Set-2 scancode byte stream into held-key, Shift, ASCII and press-count state.
// Latency: ready seen at edge N -> one-cycle pop strobe in cycle N+1 -> outputs updated after edge N+2.
// Backpressure: pops at most one byte per 3 cycles; idles indefinitely while i_ready is low.
//
// Ports:
//   i_clk         system clock (shared with the keyboard receiver)
//   i_rst         asynchronous active-high reset
//   i_ready       receiver FIFO non-empty, i_data valid
//   i_data        byte at the receiver FIFO head
//   i_overflow    receiver FIFO overflow indication, sampled every cycle
//   o_nextdata_n  registered active-low pop strobe to the receiver
//   o_key_valid   a non-Shift key is currently held
//   o_scancode    last accepted make code (prefixes stripped)
//   o_ascii       ASCII of o_scancode under the Shift state at make time
//   o_key_count   distinct key presses, modulo 256
//   o_ovf_sticky  i_overflow has been seen since reset
module kbd_scancode_decoder (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ready,
  input  logic [7:0] i_data,
  input  logic       i_overflow,
  output logic       o_nextdata_n,
  output logic       o_key_valid,
  output logic [7:0] o_scancode,
  output logic [7:0] o_ascii,
  output logic [7:0] o_key_count,
  output logic       o_ovf_sticky
);

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_DEC  = 2'd2
  } state_t;

  // Registered state
  state_t     r_state;
  logic [7:0] r_byte;
  logic       r_nextdata_n;
  logic       r_ext;
  logic       r_brk;
  logic       r_shift;
  logic       r_key_valid;
  logic [7:0] r_scancode;
  logic [7:0] r_ascii;
  logic [7:0] r_key_count;
  logic       r_ovf_sticky;

  // Next-state values
  state_t     w_state_nxt;
  logic [7:0] w_byte_nxt;
  logic       w_nextdata_n_nxt;
  logic       w_ext_nxt;
  logic       w_brk_nxt;
  logic       w_shift_nxt;
  logic       w_key_valid_nxt;
  logic [7:0] w_scancode_nxt;
  logic [7:0] w_ascii_nxt;
  logic [7:0] w_key_count_nxt;

  logic       w_is_shift;
  logic [7:0] w_ascii_lut;

  // Set-2 make code to ASCII. Letters share one offset table so the
  // case of the result is picked by a single base value.
  function automatic logic [7:0] f_ascii(input logic [7:0] code, input logic shift);
    logic [7:0] res;
    logic       letter;
    logic [4:0] off;
    res    = 8'h00;
    letter = 1'b1;
    off    = 5'd0;
    case (code)
      8'h1C: off = 5'd0;   // A
      8'h32: off = 5'd1;   // B
      8'h21: off = 5'd2;   // C
      8'h23: off = 5'd3;   // D
      8'h24: off = 5'd4;   // E
      8'h2B: off = 5'd5;   // F
      8'h34: off = 5'd6;   // G
      8'h33: off = 5'd7;   // H
      8'h43: off = 5'd8;   // I
      8'h3B: off = 5'd9;   // J
      8'h42: off = 5'd10;  // K
      8'h4B: off = 5'd11;  // L
      8'h3A: off = 5'd12;  // M
      8'h31: off = 5'd13;  // N
      8'h44: off = 5'd14;  // O
      8'h4D: off = 5'd15;  // P
      8'h15: off = 5'd16;  // Q
      8'h2D: off = 5'd17;  // R
      8'h1B: off = 5'd18;  // S
      8'h2C: off = 5'd19;  // T
      8'h3C: off = 5'd20;  // U
      8'h2A: off = 5'd21;  // V
      8'h1D: off = 5'd22;  // W
      8'h22: off = 5'd23;  // X
      8'h35: off = 5'd24;  // Y
      8'h1A: off = 5'd25;  // Z
      default: begin
        letter = 1'b0;
        case (code)
          8'h45:   res = 8'h30;
          8'h16:   res = 8'h31;
          8'h1E:   res = 8'h32;
          8'h26:   res = 8'h33;
          8'h25:   res = 8'h34;
          8'h2E:   res = 8'h35;
          8'h36:   res = 8'h36;
          8'h3D:   res = 8'h37;
          8'h3E:   res = 8'h38;
          8'h46:   res = 8'h39;
          8'h29:   res = 8'h20;  // space
          8'h5A:   res = 8'h0D;  // enter
          default: res = 8'h00;
        endcase
      end
    endcase
    if (letter) begin
      res = (shift ? 8'h41 : 8'h61) + {3'b000, off};
    end
    return res;
  endfunction

  assign w_is_shift  = (r_byte == SC_LSHIFT) || (r_byte == SC_RSHIFT);
  assign w_ascii_lut = f_ascii(r_byte, r_shift);

  // Next-state and decode logic
  always_comb begin
    w_state_nxt      = r_state;
    w_byte_nxt       = r_byte;
    w_nextdata_n_nxt = 1'b1;     // strobe is only ever low for the single POP cycle
    w_ext_nxt        = r_ext;
    w_brk_nxt        = r_brk;
    w_shift_nxt      = r_shift;
    w_key_valid_nxt  = r_key_valid;
    w_scancode_nxt   = r_scancode;
    w_ascii_nxt      = r_ascii;
    w_key_count_nxt  = r_key_count;

    case (r_state)
      S_IDLE: begin
        if (i_ready) begin
          w_byte_nxt       = i_data;
          w_nextdata_n_nxt = 1'b0;
          w_state_nxt      = S_POP;
        end
      end

      S_POP: begin
        // Receiver pops at the end of this cycle.
        w_state_nxt = S_DEC;
      end

      S_DEC: begin
        // Also the gap cycle that lets the receiver update ready.
        w_state_nxt = S_IDLE;
        if (r_byte == SC_EXT) begin
          w_ext_nxt = 1'b1;
        end else if (r_byte == SC_BRK) begin
          w_brk_nxt = 1'b1;
        end else if (r_brk) begin
          // Release: only the currently held key drops key_valid.
          if (w_is_shift) begin
            w_shift_nxt = 1'b0;
          end else if (r_byte == r_scancode) begin
            w_key_valid_nxt = 1'b0;
          end
          w_brk_nxt = 1'b0;
          w_ext_nxt = 1'b0;
        end else begin
          // Make: Shift only updates modifier state; a repeat of the held
          // key is typematic and must not count again.
          if (w_is_shift) begin
            w_shift_nxt = 1'b1;
          end else if (!(r_key_valid && (r_byte == r_scancode))) begin
            w_scancode_nxt  = r_byte;
            w_key_valid_nxt = 1'b1;
            w_key_count_nxt = r_key_count + 8'd1;
            w_ascii_nxt     = r_ext ? 8'h00 : w_ascii_lut;
          end
          w_ext_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_byte       <= 8'h00;
      r_nextdata_n <= 1'b1;
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_shift      <= 1'b0;
      r_key_valid  <= 1'b0;
      r_scancode   <= 8'h00;
      r_ascii      <= 8'h00;
      r_key_count  <= 8'h00;
    end else begin
      r_state      <= w_state_nxt;
      r_byte       <= w_byte_nxt;
      r_nextdata_n <= w_nextdata_n_nxt;
      r_ext        <= w_ext_nxt;
      r_brk        <= w_brk_nxt;
      r_shift      <= w_shift_nxt;
      r_key_valid  <= w_key_valid_nxt;
      r_scancode   <= w_scancode_nxt;
      r_ascii      <= w_ascii_nxt;
      r_key_count  <= w_key_count_nxt;
    end
  end

  // Overflow is watched every cycle regardless of decoder state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf_sticky <= 1'b0;
    end else if (i_overflow) begin
      r_ovf_sticky <= 1'b1;
    end
  end

  assign o_nextdata_n = r_nextdata_n;
  assign o_key_valid  = r_key_valid;
  assign o_scancode   = r_scancode;
  assign o_ascii      = r_ascii;
  assign o_key_count  = r_key_count;
  assign o_ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_kbd_scancode_decoder.sv
module tb_kbd_scancode_decoder;

  logic       clk;
  logic       rst;
  logic       ready;
  logic [7:0] data;
  logic       ovf;
  logic       nextdata_n;
  logic       key_valid;
  logic [7:0] scancode;
  logic [7:0] ascii;
  logic [7:0] key_count;
  logic       ovf_sticky;

  kbd_scancode_decoder dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ready      (ready),
    .i_data       (data),
    .i_overflow   (ovf),
    .o_nextdata_n (nextdata_n),
    .o_key_valid  (key_valid),
    .o_scancode   (scancode),
    .o_ascii      (ascii),
    .o_key_count  (key_count),
    .o_ovf_sticky (ovf_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       kv;
    logic [7:0] sc;
    logic [7:0] asc;
    logic [7:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];

  int n_checks;
  int n_fail;
  int pop_count;
  int cyc;
  int highs_since;
  bit pop_pending;
  bit chk_pend;
  bit prev_low;
  bit seen_low;

  // Reference model state
  logic       m_kv, m_shift, m_ext, m_brk;
  logic [7:0] m_sc, m_asc, m_cnt;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic logic [7:0] m_ascii(input logic [7:0] c, input logic sh);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == c) return 8'((sh ? 65 : 97) + i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == c) return 8'(48 + i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  task automatic m_reset();
    m_kv = 0; m_shift = 0; m_ext = 0; m_brk = 0;
    m_sc = 8'h00; m_asc = 8'h00; m_cnt = 8'h00;
  endtask

  task automatic m_decode(input logic [7:0] b);
    logic is_sh;
    is_sh = (b == 8'h12) || (b == 8'h59);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (m_brk) begin
      if (is_sh) m_shift = 0;
      else if (b == m_sc) m_kv = 0;
      m_brk = 0;
      m_ext = 0;
    end else begin
      if (is_sh) m_shift = 1;
      else if (!(m_kv && b == m_sc)) begin
        m_sc  = b;
        m_kv  = 1;
        m_cnt = m_cnt + 8'd1;
        m_asc = m_ext ? 8'h00 : m_ascii(b, m_shift);
      end
      m_ext = 0;
    end
  endtask

  task automatic drive_inputs();
    ready = (fifo_q.size() != 0);
    data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_t e;
    fifo_q.push_back(b);
    m_decode(b);
    e.kv = m_kv; e.sc = m_sc; e.asc = m_asc; e.cnt = m_cnt;
    exp_q.push_back(e);
    drive_inputs();
  endtask

  // One clock: check strobe shape at the falling edge, then act as the
  // receiver FIFO just after the rising edge and score decoded bytes.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (nextdata_n === 1'b0) begin
      n_checks++;
      if (prev_low || (seen_low && highs_since < 2)) begin
        n_fail++;
        $display("FAIL pop_strobe_shape: prev_low=%0b highs_between=%0d, required single-cycle low with >=2 high cycles between",
                 prev_low, highs_since);
      end
      prev_low = 1; seen_low = 1; highs_since = 0;
      pop_pending = 1;
      pop_count++;
    end else begin
      prev_low = 0;
      highs_since++;
      pop_pending = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (chk_pend) begin
      chk_pend = 0;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: DUT decoded a byte with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        if ({key_valid, scancode, ascii, key_count} !== e) begin
          n_fail++;
          $display("FAIL scoreboard: got kv=%0b sc=%02h asc=%02h cnt=%0d, expected kv=%0b sc=%02h asc=%02h cnt=%0d",
                   key_valid, scancode, ascii, key_count, e.kv, e.sc, e.asc, e.cnt);
        end
      end
    end
    if (pop_pending) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      chk_pend = 1;
    end
    drive_inputs();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || chk_pend) && n < 3000) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= 3000) begin
      n_fail++;
      $display("FAIL drain_timeout: fifo=%0d pending=%0d after %0d cycles, required 0", fifo_q.size(), exp_q.size(), n);
      fifo_q.delete();
      exp_q.delete();
      chk_pend = 0;
    end
  endtask

  task automatic clear_tb_state();
    fifo_q.delete();
    exp_q.delete();
    m_reset();
    pop_pending = 0; chk_pend = 0; prev_low = 0; seen_low = 0; highs_since = 0;
    drive_inputs();
  endtask

  task automatic apply_reset();
    rst = 1;
    ovf = 0;
    #1;
    clear_tb_state();
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    #1;
    n_checks++;
    if ({nextdata_n, key_valid, scancode, ascii, key_count, ovf_sticky} !== {1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: ndn=%0b kv=%0b sc=%02h asc=%02h cnt=%0d ovf=%0b, required 1 0 00 00 0 0",
               nextdata_n, key_valid, scancode, ascii, key_count, ovf_sticky);
    end
    clear_tb_state();
    step();
    step();
    rst = 0;
  endtask

  task automatic test_make_break();
    apply_reset();
    push_byte(8'h1C);
    drain();
    n_checks++;
    if ({key_valid, scancode, ascii, key_count} !== {1'b1, 8'h1C, 8'h61, 8'd1}) begin
      n_fail++;
      $display("FAIL make_a: kv=%0b sc=%02h asc=%02h cnt=%0d, required 1 1C 61 1", key_valid, scancode, ascii, key_count);
    end
    push_byte(8'hF0); push_byte(8'h1C);
    drain();
    n_checks++;
    if ({key_valid, scancode, key_count} !== {1'b0, 8'h1C, 8'd1}) begin
      n_fail++;
      $display("FAIL break_a: kv=%0b sc=%02h cnt=%0d, required 0 1C 1", key_valid, scancode, key_count);
    end
  endtask

  task automatic test_shift();
    apply_reset();
    push_byte(8'h12); push_byte(8'h1C); push_byte(8'hF0);
    push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h12);
    drain();
    n_checks++;
    if ({ascii, key_count} !== {8'h41, 8'd1}) begin
      n_fail++;
      $display("FAIL shift_upper: asc=%02h cnt=%0d, required 41 1", ascii, key_count);
    end
    push_byte(8'h1C);
    drain();
    n_checks++;
    if ({ascii, key_count} !== {8'h61, 8'd2}) begin
      n_fail++;
      $display("FAIL shift_released_lower: asc=%02h cnt=%0d, required 61 2", ascii, key_count);
    end
  endtask

  task automatic test_repeat_overlap();
    apply_reset();
    push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C);
    drain();
    n_checks++;
    if (key_count !== 8'd1) begin
      n_fail++;
      $display("FAIL typematic: cnt=%0d, required 1", key_count);
    end
    push_byte(8'h32);
    drain();
    n_checks++;
    if ({scancode, key_count} !== {8'h32, 8'd2}) begin
      n_fail++;
      $display("FAIL overlap_make: sc=%02h cnt=%0d, required 32 2", scancode, key_count);
    end
    push_byte(8'hF0); push_byte(8'h1C);
    drain();
    n_checks++;
    if ({key_valid, scancode} !== {1'b1, 8'h32}) begin
      n_fail++;
      $display("FAIL stale_release: kv=%0b sc=%02h, required 1 32", key_valid, scancode);
    end
  endtask

  task automatic test_extended();
    apply_reset();
    push_byte(8'hE0); push_byte(8'h75);
    drain();
    n_checks++;
    if ({key_valid, scancode, ascii, key_count} !== {1'b1, 8'h75, 8'h00, 8'd1}) begin
      n_fail++;
      $display("FAIL ext_make: kv=%0b sc=%02h asc=%02h cnt=%0d, required 1 75 00 1", key_valid, scancode, ascii, key_count);
    end
    push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
    drain();
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_break: kv=%0b, required 0", key_valid);
    end
    // An extended prefix must not leak into the next plain key.
    push_byte(8'h1C);
    drain();
    n_checks++;
    if (ascii !== 8'h61) begin
      n_fail++;
      $display("FAIL ext_cleared: asc=%02h, required 61", ascii);
    end
  endtask

  task automatic test_ascii_table();
    apply_reset();
    for (int i = 0; i < 26; i++) begin
      if (i % 2 == 1) push_byte(8'h12);
      push_byte(letter_codes[i]); push_byte(8'hF0); push_byte(letter_codes[i]);
      if (i % 2 == 1) begin push_byte(8'hF0); push_byte(8'h12); end
    end
    for (int i = 0; i < 10; i++) begin
      push_byte(8'h59);
      push_byte(digit_codes[i]); push_byte(8'hF0); push_byte(digit_codes[i]);
      push_byte(8'hF0); push_byte(8'h59);
    end
    push_byte(8'h29); push_byte(8'hF0); push_byte(8'h29);
    push_byte(8'h5A); push_byte(8'hF0); push_byte(8'h5A);
    push_byte(8'h76);
    drain();
    n_checks++;
    if ({scancode, ascii, key_count} !== {8'h76, 8'h00, 8'd39}) begin
      n_fail++;
      $display("FAIL ascii_table_end: sc=%02h asc=%02h cnt=%0d, required 76 00 39", scancode, ascii, key_count);
    end
  endtask

  task automatic test_count_wrap();
    apply_reset();
    for (int i = 0; i < 255; i++) begin
      logic [7:0] c;
      c = (i % 2 == 1) ? 8'h32 : 8'h1C;
      push_byte(c); push_byte(8'hF0); push_byte(c);
    end
    drain();
    n_checks++;
    if (key_count !== 8'hFF) begin
      n_fail++;
      $display("FAIL count_255: cnt=%0d, required 255", key_count);
    end
    push_byte(8'h32); push_byte(8'hF0); push_byte(8'h32);
    drain();
    n_checks++;
    if (key_count !== 8'h00) begin
      n_fail++;
      $display("FAIL count_wrap: cnt=%0d, required 0", key_count);
    end
  endtask

  task automatic test_back_to_back();
    int p0, c0;
    apply_reset();
    p0 = pop_count;
    c0 = cyc;
    push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
    push_byte(8'h32); push_byte(8'hF0); push_byte(8'h32);
    drain();
    n_checks++;
    if (pop_count - p0 != 6) begin
      n_fail++;
      $display("FAIL pop_count: got %0d pops, required 6", pop_count - p0);
    end
    n_checks++;
    if (cyc - c0 > 6 * 3 + 4) begin
      n_fail++;
      $display("FAIL throughput: %0d cycles for 6 bytes, required <= 22", cyc - c0);
    end
    p0 = pop_count;
    for (int i = 0; i < 20; i++) step();
    n_checks++;
    if (pop_count != p0 || nextdata_n !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_no_pop: %0d pops while empty ndn=%0b, required 0 pops ndn=1", pop_count - p0, nextdata_n);
    end
  endtask

  task automatic test_reset_mid_pop();
    int n;
    apply_reset();
    push_byte(8'h1C);
    drain();
    push_byte(8'hF0); push_byte(8'h1C);
    n = 0;
    while (nextdata_n !== 1'b0 && n < 20) begin step(); n++; end
    n_checks++;
    if (nextdata_n !== 1'b0) begin
      n_fail++;
      $display("FAIL reach_pop: ndn=%0b, required 0 within 20 cycles", nextdata_n);
    end
    rst = 1;
    #1;
    n_checks++;
    if ({nextdata_n, key_valid, scancode, ascii, key_count} !== {1'b1, 1'b0, 8'h00, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_mid_pop: ndn=%0b kv=%0b sc=%02h asc=%02h cnt=%0d, required 1 0 00 00 0",
               nextdata_n, key_valid, scancode, ascii, key_count);
    end
    clear_tb_state();
    step();
    step();
    rst = 0;
    push_byte(8'h1C);
    step();
    n_checks++;
    if (nextdata_n !== 1'b0) begin
      n_fail++;
      $display("FAIL first_pop_after_reset: ndn=%0b, required 0 one cycle after ready", nextdata_n);
    end
    drain();
    n_checks++;
    if ({key_valid, scancode, key_count} !== {1'b1, 8'h1C, 8'd1}) begin
      n_fail++;
      $display("FAIL restart_clean: kv=%0b sc=%02h cnt=%0d, required 1 1C 1", key_valid, scancode, key_count);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    step();
    n_checks++;
    if (ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_idle: ovf_sticky=%0b, required 0", ovf_sticky);
    end
    push_byte(8'h1C);
    ovf = 1;
    step();
    ovf = 0;
    n_checks++;
    if (ovf_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: ovf_sticky=%0b, required 1", ovf_sticky);
    end
    drain();
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (ovf_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_hold: ovf_sticky=%0b, required 1", ovf_sticky);
    end
    rst = 1;
    #1;
    n_checks++;
    if (ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf_sticky=%0b, required 0 after reset", ovf_sticky);
    end
    clear_tb_state();
    step();
    rst = 0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; pop_count = 0; cyc = 0;
    rst = 0; ovf = 0; ready = 0; data = 8'h00;
    m_reset();
    #2;
    test_reset();
    test_make_break();
    test_shift();
    test_repeat_overlap();
    test_extended();
    test_ascii_table();
    test_count_wrap();
    test_back_to_back();
    test_reset_mid_pop();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
